// File: rtl/timepulse_sequencer_if.sv
// timepulse_sequencer_if: run/stop/step controls and timepulse outputs of the AGC timepulse sequencer
interface timepulse_sequencer_if #(parameter int CNT_W = 16);
  logic run_en;
  logic stop_req;
  logic step;
  logic [11:0] tp;
  logic stopped;
  logic mct_end;
  logic [CNT_W-1:0] mct_count;
  modport master (output run_en, stop_req, step, input tp, stopped, mct_end, mct_count);
  modport slave (input run_en, stop_req, step, output tp, stopped, mct_end, mct_count);
endinterface

// File: rtl/timepulse_sequencer.sv
// timepulse_sequencer: divides clk into one-hot TP1..TP12 memory cycles with run, monitor stop and single-MCT step.
// Optional completed-MCT counter enabled by defining TPSEQ_MCT_COUNTER_EN.
module timepulse_sequencer #(
  parameter int DIV   = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  timepulse_sequencer_if.slave bus
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_d;
  logic [11:0] tp, tp_d;
  logic [PW-1:0] psc, psc_d;
  logic stop_pend, stop_pend_d, step_pend, step_pend_d;
  logic mct_end, mct_end_d;
  logic psc_top, last, go, halt_now;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tp        <= '0;
      psc       <= '0;
      stop_pend <= 1'b0;
      step_pend <= 1'b0;
      mct_end   <= 1'b0;
    end else begin
      state     <= state_d;
      tp        <= tp_d;
      psc       <= psc_d;
      stop_pend <= stop_pend_d;
      step_pend <= step_pend_d;
      mct_end   <= mct_end_d;
    end
  end
  always_comb begin
    psc_top     = psc == PW'(DIV - 1);
    last        = state == RUN && tp[11] && psc_top;
    go          = bus.step || (bus.run_en && !bus.stop_req);
    halt_now    = stop_pend || step_pend || bus.stop_req || !bus.run_en;
    state_d     = state;
    tp_d        = tp;
    psc_d       = psc;
    stop_pend_d = stop_pend;
    step_pend_d = step_pend;
    if (state != RUN) begin
      if (go) begin
        state_d     = RUN;
        tp_d        = 12'd1;
        psc_d       = '0;
        step_pend_d = bus.step;
        stop_pend_d = 1'b0;
      end
    end else if (last) begin
      state_d     = halt_now ? HALT : RUN;
      tp_d        = halt_now ? 12'd0 : 12'd1;
      psc_d       = '0;
      stop_pend_d = 1'b0;
      step_pend_d = 1'b0;
    end else begin
      stop_pend_d = stop_pend || bus.stop_req;
      tp_d        = psc_top ? tp << 1 : tp;
      psc_d       = psc_top ? '0 : psc + PW'(1);
    end
    // mct_end is registered, so it is asserted on the edge entering the final cycle
    mct_end_d = state_d == RUN && tp_d[11] && psc_d == PW'(DIV - 1);
  end
`ifdef TPSEQ_MCT_COUNTER_EN
  logic [CNT_W-1:0] mct_count;
  always_ff @(posedge clk) begin
    if (rst) mct_count <= '0;
    else if (mct_end) mct_count <= mct_count + CNT_W'(1);
  end
  assign bus.mct_count = mct_count;
`else
  assign bus.mct_count = {CNT_W{1'b0}};
`endif
  assign bus.tp      = tp;
  assign bus.stopped = state != RUN;
  assign bus.mct_end = mct_end;
endmodule

// File: tb/tb_timepulse_sequencer.sv
// tb_timepulse_sequencer: table-driven check of the DIV=4 sequencer plus a DIV=1, CNT_W=4 wrap sequence.
module tb_timepulse_sequencer;
`ifdef TPSEQ_MCT_COUNTER_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  localparam int MCT = 48;
  typedef struct {
    logic rst, run_en, stop_req, step;
    logic [11:0] tp;
    logic stopped, mct_end;
    logic [15:0] cnt;
  } vec_t;
  logic clk, rst, rst1;
  int checks, errors;
  vec_t q[$];
  timepulse_sequencer_if #(.CNT_W(16)) bus ();
  timepulse_sequencer_if #(.CNT_W(4)) bus1 ();
  timepulse_sequencer #(.DIV(4), .CNT_W(16)) u_main (.clk(clk), .rst(rst), .bus(bus));
  timepulse_sequencer #(.DIV(1), .CNT_W(4)) u_fast (.clk(clk), .rst(rst1), .bus(bus1));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask
  function automatic void add(input logic r, re, sr, st, input logic [11:0] t, input logic s, e, input int c);
    vec_t v;
    v.rst = r; v.run_en = re; v.stop_req = sr; v.step = st;
    v.tp = t; v.stopped = s; v.mct_end = e; v.cnt = 16'(c);
    q.push_back(v);
  endfunction
  function automatic void add_run(input logic re, sr, st, input int pos, input int c);
    logic [11:0] one;
    one = 12'd1;
    add(1'b0, re, sr, st, one << (pos / 4), 1'b0, pos == MCT - 1, c);
  endfunction
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; rst1 = 1'b1;
    bus.run_en = 1'b0; bus.stop_req = 1'b0; bus.step = 1'b0;
    bus1.run_en = 1'b0; bus1.stop_req = 1'b0; bus1.step = 1'b0;
    add(1, 0, 0, 0, 12'd0, 1, 0, 0);
    add(1, 1, 0, 0, 12'd0, 1, 0, 0);
    add(0, 0, 0, 0, 12'd0, 1, 0, 0);
    // three MCTs continuous; stop_req pulse inside TP5 of the third
    for (int m = 0; m < 3; m++)
      for (int p = 0; p < MCT; p++) add_run(1, m == 2 && p == 17, 0, p, m);
    add(0, 0, 0, 0, 12'd0, 1, 0, 3);
    add(0, 0, 0, 0, 12'd0, 1, 0, 3);
    // single-MCT step: plain, with stop_req, and with run_en held high
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < MCT; p++) add_run(k == 2, k == 1 && p == 0, p == 0, p, 3 + k);
      add(0, k == 2, 0, 0, 12'd0, 1, 0, 4 + k);
      add(0, 0, 0, 0, 12'd0, 1, 0, 4 + k);
    end
    add(0, 1, 1, 0, 12'd0, 1, 0, 6);
    for (int p = 0; p < 25; p++) add_run(1, 0, 0, p, 6);
    add(1, 1, 0, 0, 12'd0, 1, 0, 0);
    add(0, 0, 0, 0, 12'd0, 1, 0, 0);
    foreach (q[i]) begin
      rst = q[i].rst;
      bus.run_en = q[i].run_en;
      bus.stop_req = q[i].stop_req;
      bus.step = q[i].step;
      @(posedge clk); #1;
      chk("tp", i, 32'(bus.tp), 32'(q[i].tp));
      chk("stopped", i, 32'(bus.stopped), 32'(q[i].stopped));
      chk("mct_end", i, 32'(bus.mct_end), 32'(q[i].mct_end));
      chk("mct_count", i, 32'(bus.mct_count), CNT_ON ? 32'(q[i].cnt) : 32'd0);
    end
    // DIV=1 continuous run across counter wrap
    rst1 = 1'b0;
    bus1.run_en = 1'b1;
    for (int c = 1; c <= 16 * 12 + 1; c++) begin
      logic [11:0] one;
      one = 12'd1;
      @(posedge clk); #1;
      chk("fast_tp", c, 32'(bus1.tp), 32'(one << ((c - 1) % 12)));
      chk("fast_end", c, 32'(bus1.mct_end), 32'((c - 1) % 12 == 11));
      if (c == 13 || c == 192 || c == 193)
        chk("fast_count", c, 32'(bus1.mct_count), CNT_ON ? 32'(((c - 1) / 12) % 16) : 32'd0);
    end
    bus1.run_en = 1'b0;
    for (int c = 0; c < 13; c++) @(posedge clk);
    #1;
    chk("fast_halt_tp", 0, 32'(bus1.tp), 32'd0);
    chk("fast_halt_stopped", 0, 32'(bus1.stopped), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
